// File: rtl/seq_bypass_add_pkg.sv
// Shared types and constants for the sequential (slice-serial) adder controller.
package seq_bypass_add_pkg;

    // Controller states: waiting for operands, stepping slices, holding result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SLICE = 8;

    // Width of the slice index counter; at least one bit even for a single slice.
    function automatic int idx_width(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/seq_bypass_add_ctrl_bypass8.sv
// 8-bit carry-bypass adder cell: ripple carry inside the block, with the block
// carry-out taken straight from the carry-in when every bit propagates.
module bypass8 (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       cin_i,
    output logic [7:0] sum_o,
    output logic       cout_o
);

    logic [7:0] prop;
    logic       carry;

    // Ripple the carry bit by bit; bypass the chain when the whole block propagates.
    always_comb begin
        sum_o = '0;
        prop  = a_i ^ b_i;
        carry = cin_i;
        for (int i = 0; i < 8; i++) begin
            sum_o[i] = prop[i] ^ carry;
            carry    = (a_i[i] & b_i[i]) | (prop[i] & carry);
        end
        cout_o = (&prop) ? cin_i : carry;
    end

endmodule

// File: rtl/seq_bypass_add_ctrl.sv
// Slice-serial WIDTH-bit adder: one SLICE-bit adder reused over WIDTH/SLICE
// cycles, with the inter-slice carry kept in a register.
// Optional signed-overflow output OVF is built when SEQ_BYPASS_ADD_OVF_EN is defined.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. Input side: in_ready is high only in IDLE; the producer holds in_valid
// and operands until it sees in_ready. Output side: out_valid is high only in
// DONE; S/Cout (and OVF) stay stable until out_ready is seen at an edge.
module seq_bypass_add_ctrl
    import seq_bypass_add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             busy,
`ifdef SEQ_BYPASS_ADD_OVF_EN
    output logic             OVF,
`endif
    output state_e           dbg_state_o
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IW     = idx_width(NSLICE);
    localparam int MSB    = WIDTH - 1;

    if ((SLICE < 1) || (WIDTH % SLICE != 0)) begin : g_bad_params
        $error("seq_bypass_add_ctrl: WIDTH must be a positive multiple of SLICE");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [IW-1:0]    idx_q, idx_d;
`ifdef SEQ_BYPASS_ADD_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic [SLICE-1:0] slice_a, slice_b, slice_sum;
    logic             slice_cout;

    assign slice_a = a_q[int'(idx_q)*SLICE +: SLICE];
    assign slice_b = b_q[int'(idx_q)*SLICE +: SLICE];

    if (SLICE == 8) begin : g_bypass8
        bypass8 u_slice (
            .a_i    (slice_a),
            .b_i    (slice_b),
            .cin_i  (carry_q),
            .sum_o  (slice_sum),
            .cout_o (slice_cout)
        );
    end else begin : g_generic
        assign {slice_cout, slice_sum} = {1'b0, slice_a} + {1'b0, slice_b}
                                       + {{SLICE{1'b0}}, carry_q};
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign S           = s_q;
    assign Cout        = cout_q;
    assign dbg_state_o = state_q;
`ifdef SEQ_BYPASS_ADD_OVF_EN
    assign OVF         = ovf_q;
`endif

    // Next-state and datapath updates: accept, step one slice per cycle, hand off.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        idx_d   = idx_q;
`ifdef SEQ_BYPASS_ADD_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_d     = A;
                    b_d     = B;
                    carry_d = Cin;
                    idx_d   = '0;
                    s_d     = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                s_d[int'(idx_q)*SLICE +: SLICE] = slice_sum;
                carry_d = slice_cout;
                if (idx_q == IW'(NSLICE - 1)) begin
                    // Last slice: index is left alone so it never wraps by overflow.
                    cout_d  = slice_cout;
`ifdef SEQ_BYPASS_ADD_OVF_EN
                    ovf_d   = (a_q[MSB] == b_q[MSB]) && (slice_sum[SLICE-1] != a_q[MSB]);
`endif
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
`ifdef SEQ_BYPASS_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
`ifdef SEQ_BYPASS_ADD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

endmodule

// File: tb/tb_seq_bypass_add_ctrl.sv
// Bench for seq_bypass_add_ctrl: table of directed vectors, hand-written
// hold and reset-abort sequences, then random operands against an arithmetic model.
module tb_seq_bypass_add_ctrl;
    import seq_bypass_add_pkg::*;

    localparam int W  = 32;
    localparam int SL = 8;
    localparam int NS = W / SL;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A, B, S;
    logic         Cin;
    logic         out_valid;
    logic         out_ready;
    logic         Cout;
    logic         busy;
`ifdef SEQ_BYPASS_ADD_OVF_EN
    logic         OVF;
`endif
    state_e       dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t vecs[7];

    // Expected results in issue order: {ovf, cout, s}.
    logic [W+1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    seq_bypass_add_ctrl #(.WIDTH(W), .SLICE(SL)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .A           (A),
        .B           (B),
        .Cin         (Cin),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .S           (S),
        .Cout        (Cout),
        .busy        (busy),
`ifdef SEQ_BYPASS_ADD_OVF_EN
        .OVF         (OVF),
`endif
        .dbg_state_o (dbg_state)
    );

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference: full-width unsigned sum for S/Cout, signed range test for OVF.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin);
        longint unsigned u;
        longint          sgn;
        longint          maxv;
        longint          minv;
        logic            ovf;
        u    = longint'(a) + longint'(b) + longint'(cin);
        sgn  = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
        maxv = (longint'(1) << (W - 1)) - 1;
        minv = -(longint'(1) << (W - 1));
        ovf  = (sgn > maxv) || (sgn < minv);
        return {ovf, u[W], u[W-1:0]};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " in_ready_wait"}, in_ready, 1);
    endtask

    // Issue one operation, optionally scramble inputs while busy, hold the
    // result for 'hold' cycles, then consume it.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic [W+1:0] exp, input int hold, input bit corrupt,
                         input string tag);
        int           cyc;
        bit           busy_ok;
        logic [W+1:0] e;
        exp_q.push_back(exp);
        @(negedge clk);
        A = a; B = b; Cin = cin; in_valid = 1'b1;
        wait_ready(tag);
        @(posedge clk);
        cyc = 0;
        busy_ok = 1'b1;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                in_valid = 1'b0;
                if (corrupt) begin
                    A = '1; B = '1; Cin = 1'b1;
                end
                check({tag, " s_upper_cleared"}, S[W-1:SL], 0);
            end
            if (!busy) busy_ok = 1'b0;
        end while (!out_valid && cyc < 20);
        check({tag, " latency"}, cyc, NS + 1);
        check({tag, " busy"}, busy_ok, 1);
        e = exp_q.pop_front();
        repeat (hold) @(negedge clk);
        check({tag, " S"}, S, e[W-1:0]);
        check({tag, " Cout"}, Cout, e[W]);
`ifdef SEQ_BYPASS_ADD_OVF_EN
        check({tag, " OVF"}, OVF, e[W+1]);
`endif
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " idle_in_ready"}, in_ready, 1);
        check({tag, " idle_S_held"}, S, e[W-1:0]);
    endtask

    // ---------------- test body ----------------
    initial begin
        int n;
        logic [W-1:0] ra, rb;
        logic         rc;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; Cin = 1'b0;
        repeat (2) @(negedge clk);
        check("rst in_ready", in_ready, 1);
        check("rst out_valid", out_valid, 0);
        check("rst busy", busy, 0);
        check("rst S", S, 0);
        check("rst Cout", Cout, 0);
        check("rst state", dbg_state, IDLE);
`ifdef SEQ_BYPASS_ADD_OVF_EN
        check("rst OVF", OVF, 0);
`endif
        rst = 1'b0;

        //          a             b             cin   s             cout  ovf
        vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
        vecs[2] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vecs[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[4] = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0};
        vecs[5] = '{32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0};
        vecs[6] = '{32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0, 1'b0};

        for (int i = 0; i < 7; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin,
                  {vecs[i].ovf, vecs[i].cout, vecs[i].s},
                  0, (i == 5), $sformatf("vec%0d", i));
        end

        // Result held in DONE for 3 cycles while a new request waits.
        @(negedge clk);
        A = 32'h3; B = 32'h4; Cin = 1'b1; in_valid = 1'b1;
        wait_ready("hold");
        @(posedge clk);
        @(negedge clk);
        A = 32'h10; B = 32'h20; Cin = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("hold latency", n, NS + 1);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("hold%0d S", k), S, 32'h8);
            check($sformatf("hold%0d Cout", k), Cout, 0);
            check($sformatf("hold%0d in_ready", k), in_ready, 0);
            check($sformatf("hold%0d out_valid", k), out_valid, 1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("hold release in_ready", in_ready, 1);
        check("hold release out_valid", out_valid, 0);
        @(negedge clk);
        check("hold reaccept busy", busy, 1);
        check("hold reaccept in_ready", in_ready, 0);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("hold second latency", n, NS + 1);
        check("hold second S", S, 32'h30);
        check("hold second Cout", Cout, 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset two cycles into BUSY aborts the operation.
        @(negedge clk);
        A = 32'h12345678; B = 32'h11111111; Cin = 1'b0; in_valid = 1'b1;
        wait_ready("abort");
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort out_valid", out_valid, 0);
        check("abort S", S, 0);
        check("abort Cout", Cout, 0);
        check("abort in_ready", in_ready, 1);
        check("abort busy", busy, 0);
`ifdef SEQ_BYPASS_ADD_OVF_EN
        check("abort OVF", OVF, 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        do_op(32'h12345678, 32'h11111111, 1'b0, model(32'h12345678, 32'h11111111, 1'b0),
              0, 1'b0, "post_abort");

        // Random operands, biased toward carry-chain extremes.
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0: begin ra = '1; rb = '0; end
                1: begin rb = ~ra; end
                2: begin ra[W-1] = rb[W-1]; end
                default: ;
            endcase
            do_op(ra, rb, rc, model(ra, rb, rc), $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                  $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_bypass_add_ctrl.md
Name: seq_bypass_add_ctrl

Overview:
- Multi-cycle sequencer that computes a WIDTH-bit A+B+Cin with a single SLICE-bit carry-bypass adder slice, time-shared over WIDTH/SLICE cycles.
- Trades latency for area compared with the fully parallel chained-slice adder.
- Sits between a valid/ready producer and a valid/ready consumer. The carry is held in a register between slices.

Parameters:
- WIDTH, 32, operand/result width; must be an integer multiple of SLICE (elaboration-time check fails otherwise).
- SLICE, 8, width of the shared adder slice; NSLICE = WIDTH/SLICE is a derived localparam.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands present
- in_ready  output  1  controller can accept operands
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- Cin  input  1  carry in
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- S  output  WIDTH  sum (registered)
- Cout  output  1  carry out of MSB (registered)
- busy  output  1  high in BUSY or DONE

Behaviour:
- Clocking and reset:
  - One clock domain: clk.
  - rst is asynchronous and active-high. Asserting it forces state IDLE, S=0, Cout=0, the carry register to 0 and the slice index to 0.
  - Reset values: in_ready=1, out_valid=0, busy=0, S=0, Cout=0.
- States: IDLE, BUSY, DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
  - busy = (state!=IDLE).
- IDLE:
  - On in_valid && in_ready at a clock edge: latch A and B into operand registers, load the carry register with Cin, set idx=0, clear S, go to BUSY.
- BUSY:
  - Each cycle, slice idx adds A_r[idx*SLICE +: SLICE] + B_r[idx*SLICE +: SLICE] + carry_r.
  - At the edge: write the slice sum into S[idx*SLICE +: SLICE], set carry_r to the slice carry-out, and increment idx.
  - When idx==NSLICE-1: also load Cout with the slice carry-out and go to DONE.
- DONE:
  - S and Cout are held stable while out_ready=0.
  - On out_ready=1 at an edge: go to IDLE. There is no same-cycle re-accept; in_ready rises in the following cycle.
- Latency:
  - Handshake in cycle T → slices computed in cycles T+1..T+NSLICE → out_valid high from cycle T+NSLICE+1 (T+5 at default parameters).
  - Maximum throughput is one operation per NSLICE+2 cycles.
- Boundary conditions:
  - A, B and Cin changes while busy are ignored; the latched operands are used.
  - in_valid while not in IDLE is not accepted. The producer must hold it until in_ready.
  - idx wraps to 0 only through the IDLE accept path, never by counter overflow.
  - Carry propagates across all slices; an all-ones operand with carry-in produces Cout=1 and S=0.
  - rst asserted mid-operation aborts it. The partial result is discarded and S/Cout are cleared immediately (asynchronously).
  - S holds the previous result in IDLE until the next accept clears it.

Optional Feature:
- Macro: SEQ_BYPASS_ADD_OVF_EN.
- Defined:
  - Adds output port OVF (1 bit), registered, reset value 0.
  - Loaded on the final BUSY edge with signed two's-complement overflow: (A_r[MSB]==B_r[MSB]) && (slice_sum[SLICE-1]!=A_r[MSB]).
  - Held with S in DONE.
- Undefined: no OVF port and no related logic.

Decomposition:
- Package seq_bypass_add_pkg contains:
  - the state enum (IDLE, BUSY, DONE);
  - default constants DEF_WIDTH=32 and DEF_SLICE=8;
  - a function returning the index width, $clog2(NSLICE) with a minimum of 1.
- Sub-module: one instance of the existing bypass8 carry-bypass slice cell for SLICE=8.
- The controller holds only the FSM, operand registers, carry register, index counter and result registers.

Test Plan:
- Reset, then A=0x000000FF, B=0x00000001, Cin=0 accepted in cycle T → S=0x00000100, Cout=0, out_valid first high in T+5, busy high T+1..T+5.
- A=0xFFFFFFFF, B=0x00000000, Cin=1 → S=0x00000000, Cout=1 (carry ripples through all 4 slices); with SEQ_BYPASS_ADD_OVF_EN, OVF=0.
- A=0x80000000, B=0x80000000, Cin=0 → S=0x00000000, Cout=1, OVF=1; A=0x7FFFFFFF, B=0x00000001 → S=0x80000000, Cout=0, OVF=1.
- Hold out_ready=0 for 3 cycles in DONE while in_valid=1 → S/Cout stable, in_ready=0, no accept; out_ready=1 → IDLE next cycle, next operation accepted the cycle after and correct.
- Assert rst two cycles into BUSY → out_valid=0, S=0, Cout=0, in_ready=1 immediately; after release, A=0x12345678, B=0x11111111 → S=0x23456789, Cout=0.
- Accept A=0x0000FFFF, B=0x00000001, then drive A=B=0xFFFFFFFF during BUSY → S=0x00010000, Cout=0 (latched operands used).
